// File: rtl/morph_window_filter_if.sv
// Pixel stream bundle: one pixel per valid cycle in raster order, sof marks (0,0).
// The master modport drives the stream and the slave modport consumes it, so one
// filter stage's output can feed the next stage's input directly.
interface morph_window_filter_if #(
   parameter int unsigned PIX_W = 1
) ();

   logic             valid;
   logic             sof;
   logic [PIX_W-1:0] pixel;

   modport master (
      output valid,
      output sof,
      output pixel
   );

   modport slave (
      input valid,
      input sof,
      input pixel
   );

endinterface

// File: rtl/morph_window_filter.sv
// Streaming binary/greyscale morphology over a causal 2x2 window.
// Erode outputs the window minimum and dilate the window maximum. Pass forwards the pixel.
// Neighbours above row 0 or left of column 0 do not exist and are left out of the window.
// All outputs are registered, so each stage adds exactly one cycle of latency.
module morph_window_filter #(
   parameter int unsigned IMG_W = 160,
   parameter int unsigned IMG_H = 120,
   parameter int unsigned PIX_W = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [1:0]            mode,
   morph_window_filter_if.slave  in_if,
   morph_window_filter_if.master out_if,
   output logic                  frame_done,
   output logic [1:0]            active_mode
);

   localparam int unsigned ColW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int unsigned RowW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

   typedef enum logic [1:0] {
      OpPass   = 2'b00,
      OpErode  = 2'b01,
      OpDilate = 2'b10,
      OpPassHi = 2'b11
   } op_e;

   // Position of the next valid pixel
   logic [ColW-1:0]  col_q, col_d;
   logic [RowW-1:0]  row_q, row_d;

   // Row r-1 plus the two registered window taps
   logic [PIX_W-1:0] line_buf_q [IMG_W];
   logic [PIX_W-1:0] left_q;
   logic [PIX_W-1:0] upleft_q;

   logic [1:0]       active_mode_q;

   logic             out_valid_q;
   logic             out_sof_q;
   logic             frame_done_q;
   logic [PIX_W-1:0] out_pixel_q;

   logic [ColW-1:0]  cur_col;
   logic [RowW-1:0]  cur_row;
   logic             at_origin;
   logic             at_last;
   logic [PIX_W-1:0] up_pix;
   logic [PIX_W-1:0] win_min;
   logic [PIX_W-1:0] win_max;
   op_e              eff_op;
   logic [PIX_W-1:0] result;

   // Resolve where the current pixel sits; sof overrides the counters
   always_comb begin
      cur_col = col_q;
      cur_row = row_q;
      if (in_if.sof) begin
         cur_col = '0;
         cur_row = '0;
      end
      at_origin = (cur_col == '0) && (cur_row == '0);
      at_last   = (cur_col == ColLast) && (cur_row == RowLast);
   end

   assign up_pix = line_buf_q[cur_col];

   // Window min/max; the centre pixel is always present, so missing taps just leave it unchanged
   always_comb begin
      win_min = in_if.pixel;
      win_max = in_if.pixel;
      if (cur_col != '0) begin
         if (left_q < win_min) win_min = left_q;
         if (left_q > win_max) win_max = left_q;
      end
      if (cur_row != '0) begin
         if (up_pix < win_min) win_min = up_pix;
         if (up_pix > win_max) win_max = up_pix;
      end
      if ((cur_col != '0) && (cur_row != '0)) begin
         if (upleft_q < win_min) win_min = upleft_q;
         if (upleft_q > win_max) win_max = upleft_q;
      end
   end

   // Pixel (0,0) already runs with the freshly sampled mode
   always_comb begin
      eff_op = op_e'(at_origin ? mode : active_mode_q);
      result = in_if.pixel;
      unique case (eff_op)
         OpErode:  result = win_min;
         OpDilate: result = win_max;
         OpPass:   result = in_if.pixel;
         OpPassHi: result = in_if.pixel;
      endcase
   end

   // Raster counters advance only on valid pixels and wrap after the last pixel of the frame
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (in_if.valid) begin
         if (cur_col == ColLast) begin
            col_d = '0;
            row_d = (cur_row == RowLast) ? '0 : cur_row + RowW'(1);
         end else begin
            col_d = cur_col + ColW'(1);
            row_d = cur_row;
         end
      end
   end

   // Control state and registered outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         col_q         <= '0;
         row_q         <= '0;
         active_mode_q <= 2'b00;
         out_valid_q   <= 1'b0;
         out_sof_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         out_pixel_q   <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         out_valid_q  <= in_if.valid;
         out_sof_q    <= in_if.valid & at_origin;
         frame_done_q <= in_if.valid & at_last;
         if (in_if.valid) begin
            out_pixel_q <= result;
         end
         if (in_if.valid && at_origin) begin
            active_mode_q <= mode;
         end
      end
   end

   // Window storage; stale contents are masked for row 0 and column 0, so no reset is needed
   always_ff @(posedge clock) begin
      if (in_if.valid) begin
         upleft_q            <= up_pix;
         left_q              <= in_if.pixel;
         line_buf_q[cur_col] <= in_if.pixel;
      end
   end

   assign out_if.valid = out_valid_q;
   assign out_if.sof   = out_sof_q;
   assign out_if.pixel = out_pixel_q;
   assign frame_done   = frame_done_q;
   assign active_mode  = active_mode_q;

endmodule

// File: tb/tb_morph_window_filter.sv
// Bench for morph_window_filter on a 4x3 frame of 8-bit pixels.
// Expected outputs come from a whole-frame image model: each pixel is placed at its
// raster index, and the result is the min or max of the neighbours that exist.
module tb_morph_window_filter;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int PW = 8;

   logic          clk;
   logic          rst_n;
   logic [1:0]    mode;
   logic          frame_done;
   logic [1:0]    active_mode;

   morph_window_filter_if #(.PIX_W(PW)) in_if ();
   morph_window_filter_if #(.PIX_W(PW)) out_if ();

   morph_window_filter #(
      .IMG_W(W),
      .IMG_H(H),
      .PIX_W(PW)
   ) dut (
      .clock       (clk),
      .reset_n     (rst_n),
      .mode        (mode),
      .in_if       (in_if),
      .out_if      (out_if),
      .frame_done  (frame_done),
      .active_mode (active_mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   // Reference model state
   logic [PW-1:0] img [H][W];
   int            m_idx  = 0;
   logic [1:0]    m_mode = 2'b00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, update the model, and check the registered response
   task automatic cycle(input logic v, input logic s, input logic [PW-1:0] pix,
                        input logic [1:0] md);
      int            r;
      int            c;
      logic [PW-1:0] lo;
      logic [PW-1:0] hi;
      logic [PW-1:0] exp_pix;
      logic          exp_sof;
      logic          exp_done;
      in_if.valid = v;
      in_if.sof   = s;
      in_if.pixel = pix;
      mode        = md;
      exp_pix  = '0;
      exp_sof  = 1'b0;
      exp_done = 1'b0;
      if (v) begin
         if (s) m_idx = 0;
         r = m_idx / W;
         c = m_idx % W;
         if (m_idx == 0) m_mode = md;
         img[r][c] = pix;
         lo = pix;
         hi = pix;
         if (c > 0) begin
            if (img[r][c-1] < lo) lo = img[r][c-1];
            if (img[r][c-1] > hi) hi = img[r][c-1];
         end
         if (r > 0) begin
            if (img[r-1][c] < lo) lo = img[r-1][c];
            if (img[r-1][c] > hi) hi = img[r-1][c];
         end
         if (r > 0 && c > 0) begin
            if (img[r-1][c-1] < lo) lo = img[r-1][c-1];
            if (img[r-1][c-1] > hi) hi = img[r-1][c-1];
         end
         exp_pix  = (m_mode == 2'b01) ? lo : (m_mode == 2'b10) ? hi : pix;
         exp_sof  = (m_idx == 0);
         exp_done = (m_idx == W * H - 1);
         m_idx    = (m_idx + 1) % (W * H);
      end
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_if.valid), 32'(v));
      chk("out_sof", 32'(out_if.sof), 32'(exp_sof));
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      chk("active_mode", 32'(active_mode), 32'(m_mode));
      if (v) chk("out_pixel", 32'(out_if.pixel), 32'(exp_pix));
   endtask

   // One reset cycle with arbitrary input activity; every output must read zero
   task automatic reset_cycle();
      rst_n       = 1'b0;
      in_if.valid = 1'b1;
      in_if.sof   = 1'($urandom_range(0, 1));
      in_if.pixel = PW'($urandom);
      mode        = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_if.valid), 32'd0);
      chk("rst_out_sof", 32'(out_if.sof), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_out_pixel", 32'(out_if.pixel), 32'd0);
      chk("rst_active_mode", 32'(active_mode), 32'd0);
      rst_n       = 1'b1;
      in_if.valid = 1'b0;
      m_idx       = 0;
      m_mode      = 2'b00;
   endtask

   initial begin
      rst_n       = 1'b0;
      mode        = 2'b00;
      in_if.valid = 1'b0;
      in_if.sof   = 1'b0;
      in_if.pixel = '0;
      reset_cycle();
      reset_cycle();

      // Pass: 0..11 straight through
      for (int i = 0; i < W * H; i++) cycle(1'b1, i == 0, PW'(i), 2'b00);

      // Erode: white frame with one black pixel at (1,1)
      for (int i = 0; i < W * H; i++) cycle(1'b1, i == 0, (i == 5) ? 8'h00 : 8'hff, 2'b01);

      // Dilate: one white pixel at (0,0) on black
      for (int i = 0; i < W * H; i++) cycle(1'b1, i == 0, (i == 0) ? 8'hff : 8'h00, 2'b10);

      // Stall: three idle cycles after every fifth pixel
      for (int i = 0; i < W * H; i++) begin
         cycle(1'b1, i == 0, PW'(i), 2'b00);
         if (i % 5 == 4) begin
            for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 8'h00, 2'b00);
         end
      end

      // Mode change mid-frame, then sof at (2,1) aborts the frame
      for (int i = 0; i < 9; i++) cycle(1'b1, i == 0, PW'($urandom), (i >= 6) ? 2'b10 : 2'b01);
      for (int i = 0; i < W * H; i++) cycle(1'b1, i == 0, PW'($urandom), 2'b10);

      // Reset at (1,3); the next pixel restarts the frame without sof
      for (int i = 0; i < 7; i++) cycle(1'b1, i == 0, PW'($urandom), 2'b01);
      reset_cycle();
      for (int i = 0; i < W * H; i++) cycle(1'b1, 1'b0, PW'($urandom), 2'b10);

      // Random traffic: stalls, stray sof, mode changes, occasional reset
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset_cycle();
         end else begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, PW'($urandom),
                  2'($urandom_range(0, 3)));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
